// File: rtl/scroll_sequencer_pkg.sv
// ============================================================================
// | Module   : scroll_sequencer_pkg                                          |
// | Purpose  : Shared types and helpers for the text-buffer scroll sequencer.|
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

`ifndef CONSOLE_LINES
`define CONSOLE_LINES 25
`endif
`ifndef CONSOLE_COLUMNS
`define CONSOLE_COLUMNS 80
`endif
`ifndef MIN
`define MIN(a, b) (((a) < (b)) ? (a) : (b))
`endif

package scroll_sequencer_pkg;

    localparam int CELL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ScrollSeqState_t;

    typedef logic [CELL_W-1:0] Cell_t;

    typedef struct packed {
        logic       dir;
        logic [7:0] step;
        logic [7:0] top;
        logic [7:0] bottom;
    } Scrolling_t;

endpackage

`default_nettype wire

// File: rtl/scroll_sequencer.sv
// ============================================================================
// | Module   : scroll_sequencer                                              |
// | Purpose  : Moves text lines up/down within [top,bottom], one cell/cycle, |
// |            filling vacated lines with a blank cell.                      |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

module scroll_sequencer
    import scroll_sequencer_pkg::*;
#(
    parameter int LINES   = `CONSOLE_LINES,
    parameter int COLUMNS = `CONSOLE_COLUMNS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  Scrolling_t req_scroll,
    input  logic       abort,
    input  Cell_t      blank_cell,
    output logic       rd_en,
    output logic [7:0] rd_line,
    output logic [7:0] rd_col,
    input  Cell_t      rd_data,
    output logic       wr_en,
    output logic [7:0] wr_line,
    output logic [7:0] wr_col,
    output Cell_t      wr_data,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam logic [7:0] LAST_COL = 8'(COLUMNS - 1);
    localparam logic [8:0] LINES_9  = 9'(LINES);

    ScrollSeqState_t state, next_state;

    Scrolling_t r_cur;
    Scrolling_t r_pend;
    logic       r_pend_valid;

    logic       r_dir;
    logic [7:0] r_top;
    logic [7:0] r_bottom;
    logic [7:0] r_eff;
    logic [7:0] r_dst;
    logic [7:0] r_col;
    Cell_t      r_blank;

    logic       r_wr_en;
    logic [7:0] r_wr_line;
    logic [7:0] r_wr_col;
    logic       r_wr_copy;
    logic       r_done;
    logic       r_overflow;

    logic       w_reject;
    logic [7:0] w_span;
    logic [7:0] w_eff;
    logic [8:0] w_up_src;
    logic [8:0] w_down_lim;
    logic       w_copy;
    logic [7:0] w_src_line;
    logic       w_last_cell;
    logic       w_finish;

    assign w_reject   = (r_cur.top > r_cur.bottom) ||
                        ({1'b0, r_cur.bottom} >= LINES_9) ||
                        (r_cur.step == 8'd0);
    assign w_span     = r_cur.bottom - r_cur.top + 8'd1;
    assign w_eff      = `MIN(r_cur.step, w_span);

    // Source addresses are formed in 9 bits so dst+eff near 255 cannot wrap.
    assign w_up_src   = {1'b0, r_dst} + {1'b0, r_eff};
    assign w_down_lim = {1'b0, r_top} + {1'b0, r_eff};
    assign w_copy     = r_dir ? ({1'b0, r_dst} >= w_down_lim)
                              : (w_up_src <= {1'b0, r_bottom});
    assign w_src_line = r_dir ? (r_dst - r_eff) : w_up_src[7:0];

    assign w_last_cell = (r_col == LAST_COL) && (r_dst == (r_dir ? r_top : r_bottom));
    // An op ends either in DRAIN or by being rejected in LOAD; both hand over to a queued request.
    assign w_finish    = (state == DRAIN) || ((state == LOAD) && w_reject);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (req) next_state = LOAD;
                LOAD:    if (w_reject) next_state = (r_pend_valid || req) ? LOAD : IDLE;
                         else          next_state = RUN;
                RUN:     if (w_last_cell) next_state = DRAIN;
                DRAIN:   next_state = (r_pend_valid || req) ? LOAD : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        rd_en    = (state == RUN) && w_copy && !abort;
        rd_line  = rd_en ? w_src_line : 8'd0;
        rd_col   = rd_en ? r_col : 8'd0;
        wr_en    = r_wr_en;
        wr_line  = r_wr_line;
        wr_col   = r_wr_col;
        wr_data  = r_wr_en ? (r_wr_copy ? rd_data : r_blank) : '0;
        done     = r_done;
        overflow = r_overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_dir        <= 1'b0;
            r_top        <= 8'd0;
            r_bottom     <= 8'd0;
            r_eff        <= 8'd0;
            r_dst        <= 8'd0;
            r_col        <= 8'd0;
            r_blank      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_line    <= 8'd0;
            r_wr_col     <= 8'd0;
            r_wr_copy    <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done     <= !abort && w_finish;
            r_overflow <= !abort && req && busy && r_pend_valid && !w_finish;

            if (abort) begin
                r_pend_valid <= 1'b0;
            end else if (state == IDLE) begin
                if (req) r_cur <= req_scroll;
            end else if (w_finish) begin
                if (r_pend_valid) begin
                    r_cur        <= r_pend;
                    r_pend_valid <= req;
                    if (req) r_pend <= req_scroll;
                end else if (req) begin
                    r_cur <= req_scroll;
                end
            end else if (req && !r_pend_valid) begin
                r_pend       <= req_scroll;
                r_pend_valid <= 1'b1;
            end

            if ((state == LOAD) && !w_reject) begin
                r_dir    <= r_cur.dir;
                r_top    <= r_cur.top;
                r_bottom <= r_cur.bottom;
                r_eff    <= w_eff;
                r_dst    <= r_cur.dir ? r_cur.bottom : r_cur.top;
                r_col    <= 8'd0;
                r_blank  <= blank_cell;
            end

            if (state == RUN) begin
                if (r_col == LAST_COL) begin
                    r_col <= 8'd0;
                    r_dst <= r_dir ? (r_dst - 8'd1) : (r_dst + 8'd1);
                end else begin
                    r_col <= r_col + 8'd1;
                end
            end

            // One-stage write pipe: copies need the read data that arrives a cycle later.
            r_wr_en   <= (state == RUN) && !abort;
            r_wr_line <= r_dst;
            r_wr_col  <= r_col;
            r_wr_copy <= w_copy;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scroll_sequencer.sv
// ============================================================================
// | Module   : tb_scroll_sequencer                                           |
// | Purpose  : Self-checking bench for scroll_sequencer with a buffer model. |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

module tb_scroll_sequencer;
    import scroll_sequencer_pkg::*;

    localparam int          LINES   = 6;
    localparam int          COLUMNS = 4;
    localparam logic [15:0] BLANK   = 16'h0020;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   = 1'b0;
    logic       abort = 1'b0;
    Scrolling_t req_scroll = '0;
    Cell_t      blank_cell = BLANK;
    Cell_t      rd_data    = 16'hdead;
    logic       rd_en, wr_en, busy, done, overflow;
    logic [7:0] rd_line, rd_col, wr_line, wr_col;
    Cell_t      wr_data;

    always #5 clk = ~clk;

    scroll_sequencer #(.LINES(LINES), .COLUMNS(COLUMNS)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_scroll(req_scroll), .abort(abort),
        .blank_cell(blank_cell), .rd_en(rd_en), .rd_line(rd_line), .rd_col(rd_col),
        .rd_data(rd_data), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
        .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
    );

    logic [15:0] mem     [LINES][COLUMNS];
    logic [15:0] exp_img [LINES][COLUMNS];
    logic        preload = 1'b0;

    int checks = 0, failures = 0;
    int done_cnt = 0, ovf_cnt = 0, wr_cnt = 0, rd_cnt = 0, bad_wr = 0;
    int s_done, s_ovf, s_wr, s_rd, s_bad;
    int win_top = 0, win_bot = LINES - 1;

    // Synchronous-read buffer: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (preload) begin
            for (int l = 0; l < LINES; l++)
                for (int c = 0; c < COLUMNS; c++)
                    mem[l][c] <= {8'(l), 8'(c)};
        end else if (wr_en && int'(wr_line) < LINES && int'(wr_col) < COLUMNS) begin
            mem[int'(wr_line)][int'(wr_col)] <= wr_data;
        end
        if (rd_en && int'(rd_line) < LINES && int'(rd_col) < COLUMNS)
            rd_data <= mem[int'(rd_line)][int'(rd_col)];
        else
            rd_data <= 16'hdead;
    end

    always @(negedge clk) begin
        if (done)     done_cnt++;
        if (overflow) ovf_cnt++;
        if (rd_en)    rd_cnt++;
        if (wr_en) begin
            wr_cnt++;
            if (int'(wr_line) < win_top || int'(wr_line) > win_bot) bad_wr++;
        end
    end

    task automatic snap();
        s_done = done_cnt; s_ovf = ovf_cnt; s_wr = wr_cnt; s_rd = rd_cnt; s_bad = bad_wr;
    endtask

    task automatic preload_mem();
        @(posedge clk); #1 preload = 1'b1;
        @(posedge clk); #1 preload = 1'b0;
        for (int l = 0; l < LINES; l++)
            for (int c = 0; c < COLUMNS; c++)
                exp_img[l][c] = {8'(l), 8'(c)};
    endtask

    task automatic set_req(input int dir, input int step, input int top, input int bottom);
        req_scroll.dir    = dir[0];
        req_scroll.step   = 8'(step);
        req_scroll.top    = 8'(top);
        req_scroll.bottom = 8'(bottom);
    endtask

    function automatic bit is_reject(input int step, input int top, input int bottom);
        return (top > bottom) || (bottom >= LINES) || (step == 0);
    endfunction

    // Reference: each line in the window takes the line eff away (toward the scroll source) or blank.
    task automatic apply_model(input int dir, input int step, input int top, input int bottom);
        logic [15:0] old_img [LINES][COLUMNS];
        int span, eff, src;
        if (is_reject(step, top, bottom)) return;
        old_img = exp_img;
        span = bottom - top + 1;
        eff  = (step < span) ? step : span;
        for (int l = top; l <= bottom; l++) begin
            src = dir ? l - eff : l + eff;
            for (int c = 0; c < COLUMNS; c++) begin
                if (src >= top && src <= bottom) exp_img[l][c] = old_img[src][c];
                else                             exp_img[l][c] = BLANK;
            end
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int l = 0; l < LINES; l++)
            for (int c = 0; c < COLUMNS; c++)
                if (mem[l][c] !== exp_img[l][c]) n++;
        return n;
    endfunction

    // Issues one request and returns the req-to-done latency in cycles (-1 on timeout).
    task automatic do_op(input int dir, input int step, input int top, input int bottom,
                         output int lat);
        @(posedge clk); #1;
        set_req(dir, step, top, bottom);
        req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (wr_en !== 1'b0)    begin failures++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        checks++; if (rd_en !== 1'b0)    begin failures++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_scroll_up();
        int lat, n;
        preload_mem();
        win_top = 0; win_bot = 5;
        snap();
        do_op(0, 1, 0, 5, lat);
        apply_model(0, 1, 0, 5);
        n = mem_diff();
        checks++; if (lat !== 27) begin failures++; $display("FAIL up_latency: got %0d want 27", lat); end
        checks++; if (n !== 0) begin failures++; $display("FAIL up_contents: %0d cells differ (line5 col0 got %h want %h)", n, mem[5][0], exp_img[5][0]); end
        checks++; if (wr_cnt - s_wr !== 24) begin failures++; $display("FAIL up_writes: got %0d want 24", wr_cnt - s_wr); end
        checks++; if (done_cnt - s_done !== 1) begin failures++; $display("FAIL up_done_count: got %0d want 1", done_cnt - s_done); end
    endtask

    task automatic test_scroll_down();
        int lat, n;
        preload_mem();
        win_top = 1; win_bot = 4;
        snap();
        do_op(1, 2, 1, 4, lat);
        apply_model(1, 2, 1, 4);
        n = mem_diff();
        checks++; if (lat !== 19) begin failures++; $display("FAIL down_latency: got %0d want 19", lat); end
        checks++; if (n !== 0) begin failures++; $display("FAIL down_contents: %0d cells differ (line3 col1 got %h want %h)", n, mem[3][1], exp_img[3][1]); end
        checks++; if (bad_wr - s_bad !== 0) begin failures++; $display("FAIL down_window: got %0d stray writes want 0", bad_wr - s_bad); end
        checks++; if (rd_cnt - s_rd !== 8) begin failures++; $display("FAIL down_reads: got %0d want 8", rd_cnt - s_rd); end
    endtask

    task automatic test_clamp();
        int lat, n;
        preload_mem();
        win_top = 2; win_bot = 3;
        snap();
        do_op(0, 9, 2, 3, lat);
        apply_model(0, 9, 2, 3);
        n = mem_diff();
        checks++; if (n !== 0) begin failures++; $display("FAIL clamp_contents: %0d cells differ (line2 col0 got %h want %h)", n, mem[2][0], exp_img[2][0]); end
        checks++; if (rd_cnt - s_rd !== 0) begin failures++; $display("FAIL clamp_reads: got %0d want 0", rd_cnt - s_rd); end
        checks++; if (lat !== 11) begin failures++; $display("FAIL clamp_latency: got %0d want 11", lat); end
    endtask

    task automatic test_random();
        int lat, n, dir, step, top, bottom, span, eff, exp_lat, exp_wr, exp_rd;
        preload_mem();
        for (int k = 0; k < 12; k++) begin
            dir    = int'($urandom_range(0, 1));
            step   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
            top    = int'($urandom_range(0, 5));
            bottom = int'($urandom_range(0, 6));
            if (is_reject(step, top, bottom)) begin
                win_top = LINES; win_bot = -1;
                exp_lat = 2; exp_wr = 0; exp_rd = 0;
            end else begin
                win_top = top; win_bot = bottom;
                span    = bottom - top + 1;
                eff     = (step < span) ? step : span;
                exp_lat = span * COLUMNS + 3;
                exp_wr  = span * COLUMNS;
                exp_rd  = (span - eff) * COLUMNS;
            end
            snap();
            do_op(dir, step, top, bottom, lat);
            apply_model(dir, step, top, bottom);
            n = mem_diff();
            checks++; if (lat !== exp_lat) begin failures++; $display("FAIL rand%0d_latency: got %0d want %0d (d%0d s%0d t%0d b%0d)", k, lat, exp_lat, dir, step, top, bottom); end
            checks++; if (n !== 0) begin failures++; $display("FAIL rand%0d_contents: %0d cells differ (d%0d s%0d t%0d b%0d)", k, n, dir, step, top, bottom); end
            checks++; if (wr_cnt - s_wr !== exp_wr || rd_cnt - s_rd !== exp_rd) begin failures++; $display("FAIL rand%0d_traffic: wr %0d rd %0d want wr %0d rd %0d", k, wr_cnt - s_wr, rd_cnt - s_rd, exp_wr, exp_rd); end
            checks++; if (bad_wr - s_bad !== 0) begin failures++; $display("FAIL rand%0d_window: got %0d stray writes want 0", k, bad_wr - s_bad); end
        end
    endtask

    task automatic test_back_to_back();
        int n, d1, d2, ovf_at;
        preload_mem();
        win_top = 0; win_bot = 5;
        snap();
        d1 = -1; d2 = -1; ovf_at = -1;
        @(posedge clk); #1;
        set_req(0, 1, 0, 5); req = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (done) begin
                if (d1 < 0) d1 = cyc; else d2 = cyc;
            end
            if (overflow) ovf_at = cyc;
            if (cyc == 5) begin set_req(1, 1, 0, 5); req = 1'b1; end
            if (cyc == 8) begin set_req(0, 2, 0, 5); req = 1'b1; end
        end
        @(negedge clk); #1;
        apply_model(0, 1, 0, 5);
        apply_model(1, 1, 0, 5);
        n = mem_diff();
        checks++; if (d1 !== 27 || d2 !== 53) begin failures++; $display("FAIL b2b_done_cycles: got %0d,%0d want 27,53", d1, d2); end
        checks++; if (done_cnt - s_done !== 2) begin failures++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - s_done); end
        checks++; if (ovf_cnt - s_ovf !== 1 || ovf_at !== 9) begin failures++; $display("FAIL b2b_overflow: got %0d pulses at %0d want 1 at 9", ovf_cnt - s_ovf, ovf_at); end
        checks++; if (n !== 0) begin failures++; $display("FAIL b2b_contents: %0d cells differ", n); end
    endtask

    task automatic test_abort();
        int late_wr, busy_bad;
        preload_mem();
        win_top = 0; win_bot = 5;
        snap();
        late_wr = 0; busy_bad = 0;
        @(posedge clk); #1;
        set_req(0, 1, 0, 5); req = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0; abort = 1'b0;
            if (cyc >= 11 && wr_en) late_wr++;
            if (cyc >= 12 && busy)  busy_bad++;
            if (cyc == 5)  begin set_req(1, 1, 0, 5); req = 1'b1; end
            if (cyc == 10) abort = 1'b1;
        end
        @(negedge clk); #1;
        checks++; if (late_wr !== 0) begin failures++; $display("FAIL abort_late_writes: got %0d want 0", late_wr); end
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL abort_busy: got %0d busy cycles want 0", busy_bad); end
        checks++; if (done_cnt - s_done !== 0) begin failures++; $display("FAIL abort_done: got %0d want 0", done_cnt - s_done); end
        snap();
        @(posedge clk); #1;
        set_req(0, 1, 0, 5); req = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_req_same_cycle: busy got %b want 0", busy); end
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (wr_cnt - s_wr !== 0 || done_cnt - s_done !== 0) begin failures++; $display("FAIL abort_req_quiet: wr %0d done %0d want 0 0", wr_cnt - s_wr, done_cnt - s_done); end
    endtask

    task automatic test_reject();
        int lat;
        int tbl [3][3] = '{'{1, 4, 2}, '{0, 0, 5}, '{2, 1, 6}};
        win_top = LINES; win_bot = -1;
        for (int k = 0; k < 3; k++) begin
            snap();
            do_op(k % 2, tbl[k][0], tbl[k][1], tbl[k][2], lat);
            checks++; if (lat !== 2) begin failures++; $display("FAIL reject%0d_latency: got %0d want 2", k, lat); end
            checks++; if (wr_cnt - s_wr !== 0) begin failures++; $display("FAIL reject%0d_writes: got %0d want 0", k, wr_cnt - s_wr); end
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [52:0] outs;
        preload_mem();
        @(posedge clk); #1;
        set_req(0, 1, 0, 5); req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        outs = {busy, done, overflow, rd_en, wr_en, rd_line, rd_col, wr_line, wr_col, wr_data};
        checks++; if (outs !== '0) begin failures++; $display("FAIL async_reset_outputs: got %h want 0", outs); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_idle: busy got %b want 0", busy); end
        win_top = LINES; win_bot = -1;
        do_op(0, 0, 0, 5, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL async_reset_recover: latency got %0d want 2", lat); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scroll_up();
        test_scroll_down();
        test_clamp();
        test_random();
        test_back_to_back();
        test_abort();
        test_reject();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
